// File: rtl/axi_master_fsm_if.sv
// AXI4-Lite-style write/read channel bundle between the command initiator and the memory slave.
// M_* signals are driven by the initiator and S_* signals by the slave; M_BLEN carries the read lane mask.
interface axi_master_fsm_if;
    logic        M_AWVALID;
    logic [31:0] M_AWADDR;
    logic        S_AWREADY;

    logic        M_WVALID;
    logic [31:0] M_WDATA;
    logic [3:0]  M_WSTRB;
    logic        S_WREADY;

    logic        M_BREADY;
    logic        S_BVALID;
    logic [1:0]  S_BRESP;

    logic        M_ARVALID;
    logic [31:0] M_ARADDR;
    logic [3:0]  M_BLEN;
    logic        S_ARREADY;

    logic        M_RREADY;
    logic        S_RVALID;
    logic [31:0] S_RDATA;

    modport master (
        output M_AWVALID, M_AWADDR, M_WVALID, M_WDATA, M_WSTRB, M_BREADY,
               M_ARVALID, M_ARADDR, M_BLEN, M_RREADY,
        input  S_AWREADY, S_WREADY, S_BVALID, S_BRESP, S_ARREADY, S_RVALID, S_RDATA
    );

    modport slave (
        input  M_AWVALID, M_AWADDR, M_WVALID, M_WDATA, M_WSTRB, M_BREADY,
               M_ARVALID, M_ARADDR, M_BLEN, M_RREADY,
        output S_AWREADY, S_WREADY, S_BVALID, S_BRESP, S_ARREADY, S_RVALID, S_RDATA
    );
endinterface

// File: rtl/axi_master_fsm.sv
// Single-outstanding AXI4-Lite-style initiator: one command in, one AW/W/B write or AR/R read out,
// one response pulse back. All outputs are registered; the current state is exported on state_dbg.
module axi_master_fsm #(
    parameter int TIMEOUT_CYCLES = 256,
    parameter int TO_W           = 9
) (
    input  logic             S_ACLK,
    input  logic             S_ARRESET_N,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_write,
    input  logic [31:0]      cmd_addr,
    input  logic [31:0]      cmd_wdata,
    input  logic [3:0]       cmd_strb,
    output logic             rsp_valid,
    output logic             rsp_write,
    output logic [1:0]       rsp_resp,
    output logic [31:0]      rsp_rdata,
    output logic [2:0]       state_dbg,
    axi_master_fsm_if.master bus
);

    // Every channel transfers on a rising edge where its VALID and READY are both high;
    // a VALID, once raised, stays high with a stable payload until that transfer happens.

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_AW_W = 3'd1,
        WR_RESP = 3'd2,
        RD_AR   = 3'd3,
        RD_DATA = 3'd4,
        RSP     = 3'd5
    } state_t;

    localparam bit            TO_EN   = (TIMEOUT_CYCLES > 0);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    state_t            state_q, state_d;
    logic              cmd_ready_q, cmd_ready_d;
    logic              awvalid_q, awvalid_d;
    logic              wvalid_q, wvalid_d;
    logic              bready_q, bready_d;
    logic              arvalid_q, arvalid_d;
    logic              rready_q, rready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_write_q, rsp_write_d;
    logic [1:0]        rsp_resp_q, rsp_resp_d;
    logic [31:0]       rsp_rdata_q, rsp_rdata_d;
    logic [31:0]       addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [3:0]        strb_q, strb_d;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;

    logic accept;
    logic aw_done;
    logic w_done;
    logic to_hit;

    assign accept  = cmd_valid && cmd_ready_q;
    assign aw_done = !awvalid_q || bus.S_AWREADY;
    assign w_done  = !wvalid_q || bus.S_WREADY;
    assign to_hit  = TO_EN && (to_cnt_q == TO_LAST);

    always_ff @(posedge S_ACLK or negedge S_ARRESET_N) begin
        if (!S_ARRESET_N) begin
            state_q     <= IDLE;
            cmd_ready_q <= 1'b0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_write_q <= 1'b0;
            rsp_resp_q  <= 2'b00;
            rsp_rdata_q <= 32'd0;
            addr_q      <= 32'd0;
            wdata_q     <= 32'd0;
            strb_q      <= 4'd0;
            to_cnt_q    <= '0;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            bready_q    <= bready_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_write_q <= rsp_write_d;
            rsp_resp_q  <= rsp_resp_d;
            rsp_rdata_q <= rsp_rdata_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            strb_q      <= strb_d;
            to_cnt_q    <= to_cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = cmd_write ? WR_AW_W : RD_AR;
            WR_AW_W: if (aw_done && w_done) state_d = WR_RESP;
            WR_RESP: if (bus.S_BVALID || to_hit) state_d = RSP;
            RD_AR:   if (bus.S_ARREADY) state_d = RD_DATA;
            RD_DATA: if (bus.S_RVALID || to_hit) state_d = RSP;
            RSP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Computes the next value of every registered output from the current state and next state.
    always_comb begin
        cmd_ready_d = (state_d == IDLE);
        awvalid_d   = 1'b0;
        wvalid_d    = 1'b0;
        bready_d    = 1'b0;
        arvalid_d   = 1'b0;
        rready_d    = 1'b0;
        rsp_valid_d = 1'b0;
        rsp_write_d = rsp_write_q;
        rsp_resp_d  = rsp_resp_q;
        rsp_rdata_d = rsp_rdata_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        strb_d      = strb_q;
        to_cnt_d    = '0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    addr_d    = cmd_addr;
                    wdata_d   = cmd_wdata;
                    strb_d    = cmd_strb;
                    awvalid_d = cmd_write;
                    wvalid_d  = cmd_write;
                    arvalid_d = !cmd_write;
                end
            end
            WR_AW_W: begin
                awvalid_d = awvalid_q && !bus.S_AWREADY;
                wvalid_d  = wvalid_q && !bus.S_WREADY;
                bready_d  = (state_d == WR_RESP);
            end
            WR_RESP: begin
                bready_d = (state_d == WR_RESP);
                to_cnt_d = to_cnt_q + TO_W'(1);
                if (state_d == RSP) begin
                    rsp_valid_d = 1'b1;
                    rsp_write_d = 1'b1;
                    rsp_rdata_d = 32'd0;
                    rsp_resp_d  = bus.S_BVALID ? bus.S_BRESP : 2'b11;
                end
            end
            RD_AR: begin
                arvalid_d = !bus.S_ARREADY;
                rready_d  = bus.S_ARREADY;
            end
            RD_DATA: begin
                rready_d = (state_d == RD_DATA);
                to_cnt_d = to_cnt_q + TO_W'(1);
                if (state_d == RSP) begin
                    rsp_valid_d = 1'b1;
                    rsp_write_d = 1'b0;
                    rsp_rdata_d = bus.S_RVALID ? bus.S_RDATA : 32'd0;
                    rsp_resp_d  = bus.S_RVALID ? 2'b00 : 2'b11;
                end
            end
            RSP: begin
            end
            default: begin
            end
        endcase
    end

    assign cmd_ready     = cmd_ready_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_write     = rsp_write_q;
    assign rsp_resp      = rsp_resp_q;
    assign rsp_rdata     = rsp_rdata_q;
    assign state_dbg     = state_q;
    assign bus.M_AWVALID = awvalid_q;
    assign bus.M_AWADDR  = addr_q;
    assign bus.M_WVALID  = wvalid_q;
    assign bus.M_WDATA   = wdata_q;
    assign bus.M_WSTRB   = strb_q;
    assign bus.M_BREADY  = bready_q;
    assign bus.M_ARVALID = arvalid_q;
    assign bus.M_ARADDR  = addr_q;
    assign bus.M_BLEN    = strb_q;
    assign bus.M_RREADY  = rready_q;

endmodule
